// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset sequencer: request collection, hold window, staggered domain release
// and sticky reset-cause register.
module rst_seq_ctrl #(
   parameter int unsigned NumDomains    = 3,
   parameter int unsigned HoldCycles    = 16,
   parameter int unsigned StaggerCycles = 4,
   parameter int unsigned CntW          = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ndmreset_i,
   input  logic                  wdog_rst_i,
   input  logic                  sw_rst_req_i,
   input  logic                  iccm_rst_ni,
   input  logic                  cause_clr_i,
   output logic [NumDomains-1:0] domain_rst_no,
   output logic [4:0]            rst_cause_o,
   output logic                  busy_o
);

   localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
   localparam logic [CntW-1:0] StagLast = CntW'(StaggerCycles - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StRelease = 2'd1,
      StRun     = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [NumDomains-1:0] dom_q, dom_d;
   logic                  busy_q, busy_d;
   logic [4:0]            cause_q, cause_d;
   logic [3:0]            req_bits;
   logic                  req;

   assign req_bits = {~iccm_rst_ni, sw_rst_req_i, wdog_rst_i, ndmreset_i};
   assign req      = |req_bits;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      case (state_q)
         StHold: begin
            // Requests held high pin the counter, so the window restarts when the last one drops.
            if (req) begin
               cnt_d = '0;
            end else if (cnt_q == HoldLast) begin
               dom_d[0] = 1'b1;
               cnt_d    = '0;
               idx_d    = IdxW'(1);
               state_d  = (NumDomains == 1) ? StRun : StRelease;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRelease: begin
            if (req) begin
               dom_d   = '0;
               cnt_d   = '0;
               state_d = StHold;
            end else if (cnt_q == StagLast) begin
               for (int i = 0; i < NumDomains; i++) begin
                  if (IdxW'(i) == idx_q) dom_d[i] = 1'b1;
               end
               idx_d = idx_q + 1'b1;
               cnt_d = '0;
               if (idx_q == IdxLast) state_d = StRun;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            if (req) begin
               dom_d   = '0;
               cnt_d   = '0;
               state_d = StHold;
            end
         end
         default: begin
            dom_d   = '0;
            cnt_d   = '0;
            state_d = StHold;
         end
      endcase
   end

   assign busy_d = (dom_d != {NumDomains{1'b1}});

   // A clear coinciding with a request keeps only the bits of the requests active this cycle.
   assign cause_d = cause_clr_i ? {req_bits, 1'b0} : (cause_q | {req_bits, 1'b0});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StHold;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         busy_q  <= 1'b1;
         cause_q <= 5'b00001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   assign domain_rst_no = dom_q;
   assign rst_cause_o   = cause_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - scoreboard bench for rst_seq_ctrl: timed expectations queued at stimulus,
// checked on the falling edge once the DUT reaches the expected cycle.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ndm, wdog, sw, iccm_n, clr;
   logic [2:0] dom;
   logic [4:0] cause;
   logic       busy;

   int cyc   = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      int         c;
      logic [2:0] d;
      logic       b;
      logic [4:0] k;
      string      tag;
   } exp_t;

   exp_t q[$];

   rst_seq_ctrl #(
      .NumDomains(3), .HoldCycles(16), .StaggerCycles(4), .CntW(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .ndmreset_i(ndm), .wdog_rst_i(wdog),
      .sw_rst_req_i(sw), .iccm_rst_ni(iccm_n), .cause_clr_i(clr),
      .domain_rst_no(dom), .rst_cause_o(cause), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].c <= cyc) begin
         e = q.pop_front();
         tests++;
         assert (dom === e.d && busy === e.b && cause === e.k)
         else begin
            fails++;
            $error("FAIL %s cyc=%0d observed dom=%b busy=%b cause=%b expected dom=%b busy=%b cause=%b",
                   e.tag, cyc, dom, busy, cause, e.d, e.b, e.k);
         end
      end
   end

   task automatic push(input int c, input logic [2:0] d, input logic b, input logic [4:0] k,
                       input string tag);
      exp_t e;
      e.c = c; e.d = d; e.b = b; e.k = k; e.tag = tag;
      q.push_back(e);
   endtask

   // Full release sequence when the last request is sampled at edge base.
   task automatic seq(input int base, input logic [4:0] k, input string tag);
      push(base,      3'b000, 1'b1, k, {tag, "_hold"});
      push(base + 15, 3'b000, 1'b1, k, {tag, "_hold_end"});
      push(base + 16, 3'b001, 1'b1, k, {tag, "_dom0"});
      push(base + 19, 3'b001, 1'b1, k, {tag, "_dom0_end"});
      push(base + 20, 3'b011, 1'b1, k, {tag, "_dom1"});
      push(base + 23, 3'b011, 1'b1, k, {tag, "_dom1_end"});
      push(base + 24, 3'b111, 1'b0, k, {tag, "_run"});
   endtask

   task automatic chk(input string tag, input logic [2:0] d, input logic b, input logic [4:0] k);
      tests++;
      assert (dom === d && busy === b && cause === k)
      else begin
         fails++;
         $error("FAIL %s observed dom=%b busy=%b cause=%b expected dom=%b busy=%b cause=%b",
                tag, dom, busy, cause, d, b, k);
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $error("FAIL %s_timeout observed pending=%0d expected pending=0", tag, q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; ndm = 1'b0; wdog = 1'b0; sw = 1'b0; iccm_n = 1'b1; clr = 1'b0;

      // Power-on reset
      repeat (5) @(negedge clk);
      chk("por_in_reset", 3'b000, 1'b1, 5'b00001);
      rst_n = 1'b1;
      seq(cyc, 5'b00001, "por");
      drain("por");

      // Software pulse in RUN
      sw = 1'b1;
      seq(cyc + 1, 5'b01001, "sw");
      @(negedge clk);
      sw = 1'b0;
      drain("sw");

      // Watchdog level held high: window restarts after it drops
      wdog = 1'b1;
      n = cyc + 1;
      push(n,      3'b000, 1'b1, 5'b01101, "wdog_assert");
      push(n + 20, 3'b000, 1'b1, 5'b01101, "wdog_held");
      seq(n + 40, 5'b01101, "wdog");
      repeat (41) @(negedge clk);
      wdog = 1'b0;
      drain("wdog");

      // ndmreset at the edge domain 1 would release
      sw = 1'b1;
      n = cyc + 1;
      push(n,      3'b000, 1'b1, 5'b01101, "ndm_sw_hold");
      push(n + 16, 3'b001, 1'b1, 5'b01101, "ndm_sw_dom0");
      push(n + 19, 3'b001, 1'b1, 5'b01101, "ndm_pre_abort");
      seq(n + 20, 5'b01111, "ndm");
      @(negedge clk);
      sw = 1'b0;
      repeat (19) @(negedge clk);
      ndm = 1'b1;
      @(negedge clk);
      ndm = 1'b0;
      drain("ndm");

      // Clear coinciding with an ICCM request
      clr = 1'b1;
      iccm_n = 1'b0;
      seq(cyc + 1, 5'b10000, "clr_iccm");
      @(negedge clk);
      clr = 1'b0;
      iccm_n = 1'b1;
      drain("clr_iccm");

      // Clear alone wipes every bit, including POR
      clr = 1'b1;
      push(cyc + 1, 3'b111, 1'b0, 5'b00000, "clr_only");
      @(negedge clk);
      clr = 1'b0;
      drain("clr_only");

      // Asynchronous reset while mid-release
      sw = 1'b1;
      n = cyc + 1;
      push(n,      3'b000, 1'b1, 5'b01000, "async_sw_hold");
      push(n + 21, 3'b011, 1'b1, 5'b01000, "async_mid_release");
      @(negedge clk);
      sw = 1'b0;
      drain("async_pre");
      #2 rst_n = 1'b0;
      #1 chk("async_immediate", 3'b000, 1'b1, 5'b00001);
      @(negedge clk);
      chk("async_held", 3'b000, 1'b1, 5'b00001);
      @(negedge clk);
      rst_n = 1'b1;
      seq(cyc, 5'b00001, "por2");
      drain("por2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the azadi SoC. It collects reset requests from POR, debug (ndmreset), watchdog, software and ICCM loader. It holds all downstream reset domains asserted for a programmable minimum time, then releases them one at a time in a fixed order, domain 0 first. It also records a sticky reset-cause register readable by software.

Parameters:
NumDomains, 3, number of sequenced reset domains (1..8)
HoldCycles, 16, minimum cycles all domains stay asserted after the last request drops (>=2)
StaggerCycles, 4, cycles between successive domain releases (>=1)
CntW, 8, counter width; must hold max(HoldCycles, StaggerCycles)-1

Ports:
clk_i  in  1  system clock
rst_ni  in  1  power-on reset; asynchronous assert, active-low; deassertion already synchronised to clk_i upstream
ndmreset_i  in  1  debug non-debug-module reset request, level, active-high
wdog_rst_i  in  1  watchdog reset request, level, active-high
sw_rst_req_i  in  1  software reset request, single-cycle pulse
iccm_rst_ni  in  1  ICCM loader reset request, level, active-low
cause_clr_i  in  1  clear reset-cause register, single-cycle pulse
domain_rst_no  out  NumDomains  per-domain reset, active-low, registered
rst_cause_o  out  5  sticky cause: [0] POR, [1] ndm, [2] wdog, [3] sw, [4] iccm
busy_o  out  1  high while any domain is held in reset

Behaviour:
- All request inputs are synchronous to clk_i. req = ndmreset_i | wdog_rst_i | sw_rst_req_i | !iccm_rst_ni.
- Reset (rst_ni low, asynchronous):
  - state=HOLD, cnt=0, idx=0
  - domain_rst_no=all 0, busy_o=1
  - rst_cause_o=5'b00001
- State HOLD:
  - If req: cnt<=0.
  - Else if cnt==HoldCycles-1: domain_rst_no[0]<=1, cnt<=0, idx<=1, state<=RELEASE. If NumDomains==1, state<=RUN and busy_o<=0 instead.
  - Else: cnt<=cnt+1.
- State RELEASE:
  - If req: domain_rst_no<=0, cnt<=0, state<=HOLD.
  - Else if cnt==StaggerCycles-1: domain_rst_no[idx]<=1, idx<=idx+1, cnt<=0. If idx==NumDomains-1, state<=RUN and busy_o<=0 on the same edge.
  - Else: cnt<=cnt+1.
- State RUN:
  - If req: domain_rst_no<=0, busy_o<=1, cnt<=0, state<=HOLD.
  - Assertion is visible the cycle after the request is sampled (1-cycle latency).
- Timing:
  - With request sampled at edge N and dropped before edge N+1, domain i rises at edge N+HoldCycles+i*StaggerCycles.
  - After rst_ni deasserts, domain 0 rises at the HoldCycles-th clock edge.
- Level requests held high keep cnt at 0; the hold window restarts from the cycle the last request drops.
- Released domains never re-release out of order. Any request in RELEASE re-asserts all domains at once, including those already released.
- Cause register:
  - Every cycle, each active request sets its bit.
  - cause_clr_i clears all bits. If clear and request coincide, the request bit is set and the other bits are cleared.
  - Bit 0 is set only by rst_ni.
  - Clearing is permitted in any state.
- Simultaneous requests: all corresponding cause bits set; single restart of the sequence.
- busy_o == (domain_rst_no != all ones), registered.

Test Plan:
- POR: hold rst_ni low 5 cycles, release → domain_rst_no=3'b000 until edge 16, then 3'b001 at 16, 3'b011 at 20, 3'b111 at 24; busy_o falls at 24; rst_cause_o=5'b00001.
- SW pulse in RUN at edge N → domain_rst_no=3'b000 after edge N; domains rise at N+16, N+20, N+24; rst_cause_o=5'b01001.
- wdog_rst_i held high 40 cycles from edge N → domains stay 0 through N+40; domain 0 rises at N+40+16; cause bit 2 set.
- ndmreset_i pulse at the edge domain 1 would release (N+20) → domain_rst_no returns to 3'b000; new release at N+20+16 for domain 0; cause bit 1 set.
- cause_clr_i and iccm_rst_ni low in the same cycle → rst_cause_o=5'b10000; full reset sequence restarts.
- Assert rst_ni mid-RELEASE (domain_rst_no=3'b011) → domain_rst_no=3'b000 and busy_o=1 immediately, without a clock edge; rst_cause_o=5'b00001.
